// File: rtl/rv_ctl.sv
// ============================================================================
// Module   : rv_ctl
// Purpose  : Multicycle control FSM for the simple RISC-V core (beside rv_dp)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_ctl #(
    parameter int DPWIDTH = 32,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic [1:0]         asel,
    output logic               bff,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               dmem_wen,
    output logic               trap,
    output logic [CNTW-1:0]    instret
);

    localparam logic       c_PC_PLUS4   = 1'b0;
    localparam logic       c_PC_ALU     = 1'b1;
    localparam logic [1:0] c_WB_ALUOUT  = 2'd0;
    localparam logic [1:0] c_WB_MDR     = 2'd1;
    localparam logic [1:0] c_WB_PC      = 2'd2;
    localparam logic [1:0] c_IMM_L      = 2'd0;
    localparam logic [1:0] c_IMM_S      = 2'd1;
    localparam logic [1:0] c_IMM_B      = 2'd2;
    localparam logic [1:0] c_IMM_J      = 2'd3;
    localparam logic [1:0] c_ALUA_REG   = 2'd0;
    localparam logic [1:0] c_ALUA_PCC   = 2'd2;
    localparam logic       c_ALUB_REG   = 1'b0;
    localparam logic       c_ALUB_IMM   = 1'b1;
    localparam logic       c_REGULAR_B  = 1'b0;
    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_SLL    = 4'd2;
    localparam logic [3:0] c_ALU_SLT    = 4'd3;
    localparam logic [3:0] c_ALU_SLTU   = 4'd4;
    localparam logic [3:0] c_ALU_XOR    = 4'd5;
    localparam logic [3:0] c_ALU_SRL    = 4'd6;
    localparam logic [3:0] c_ALU_SRA    = 4'd7;
    localparam logic [3:0] c_ALU_OR     = 4'd8;
    localparam logic [3:0] c_ALU_AND    = 4'd9;
    localparam logic [6:0] c_OP_R       = 7'b0110011;
    localparam logic [6:0] c_OP_I       = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OP_STORE   = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNTW-1:0]   r_instret;
    logic              w_retire;
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_alt;
    logic              w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_alt    = instr[30];
    assign w_unused = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        pcsourse = c_PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        wbsel    = c_WB_ALUOUT;
        regwen   = 1'b0;
        immsel   = c_IMM_L;
        asel     = c_ALUA_REG;
        bsel     = c_ALUB_REG;
        alusel   = c_ALU_ADD;
        mdrwrite = 1'b0;
        dmem_wen = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    irwrite = 1'b1;
                    pccen   = 1'b1;
                    pcwrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target into aluout.
                asel   = c_ALUA_PCC;
                bsel   = c_ALUB_IMM;
                immsel = (w_opcode == c_OP_JAL) ? c_IMM_J : c_IMM_B;
                case (w_opcode)
                    c_OP_R:      w_next = S_EXEC_R;
                    c_OP_I:      w_next = S_EXEC_I;
                    c_OP_LOAD:   w_next = S_MEMADR;
                    c_OP_STORE:  w_next = S_MEMADR;
                    c_OP_BRANCH: w_next = S_BRANCH;
                    c_OP_JAL:    w_next = S_JAL;
                    default:     w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alusel = alu_decode(w_funct3, w_alt);
                w_next = S_ALUWB;
            end
            S_EXEC_I: begin
                // Only SRAI uses instr[30]; for other I-ops it is immediate data.
                bsel   = c_ALUB_IMM;
                immsel = c_IMM_L;
                alusel = alu_decode(w_funct3, w_alt && (w_funct3 == 3'b101));
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwen   = 1'b1;
                wbsel    = c_WB_ALUOUT;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMADR: begin
                bsel   = c_ALUB_IMM;
                immsel = w_opcode[5] ? c_IMM_S : c_IMM_L;
                w_next = w_opcode[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (dmem_ready) begin
                    mdrwrite = 1'b1;
                    w_next   = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwen   = 1'b1;
                wbsel    = c_WB_MDR;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                dmem_wen = 1'b1;
                if (dmem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alusel   = c_ALU_SUB;
                pcsourse = c_PC_ALU;
                case (w_funct3)
                    3'b000: begin
                        pcwrite  = zero;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    3'b001: begin
                        pcwrite  = !zero;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                pcwrite  = 1'b1;
                pcsourse = c_PC_ALU;
                regwen   = 1'b1;
                wbsel    = c_WB_PC;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        if (!rst) begin
            pcwrite  = 1'b0;
            pccen    = 1'b0;
            irwrite  = 1'b0;
            regwen   = 1'b0;
            mdrwrite = 1'b0;
            dmem_wen = 1'b0;
        end
    end

    assign trap    = (r_state == S_TRAP);
    assign bff     = c_REGULAR_B;
    assign instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_rv_ctl.sv
// ============================================================================
// Module   : tb_rv_ctl
// Purpose  : Scoreboard bench for rv_ctl using directed instruction vectors
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_ctl;
    localparam int CNTW = 4;

    localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] IMM_L = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3;
    localparam logic [1:0] ALUA_PCC = 2'd2;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    logic clk = 1'b0;
    logic rst, zero, imem_ready, dmem_ready;
    logic [31:0] instr;
    logic pcsourse, pcwrite, pccen, irwrite, regwen, bff, bsel, mdrwrite, dmem_wen, trap;
    logic [1:0] wbsel, immsel, asel;
    logic [3:0] alusel;
    logic [CNTW-1:0] instret;

    rv_ctl #(.DPWIDTH(32), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bff(bff),
        .bsel(bsel), .alusel(alusel), .mdrwrite(mdrwrite), .dmem_wen(dmem_wen),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcsourse, pcwrite, pccen, irwrite;
        logic [1:0] wbsel;
        logic       regwen;
        logic [1:0] immsel, asel;
        logic       bff, bsel;
        logic [3:0] alusel;
        logic       mdrwrite, dmem_wen, trap;
    } ctl_t;

    typedef struct {
        ctl_t            ctl;
        logic [CNTW-1:0] cnt;
        string           tag;
    } exp_t;

    exp_t            q[$];
    int              vectors = 0;
    int              errors  = 0;
    logic            mon_en  = 1'b0;
    logic [CNTW-1:0] exp_cnt = '0;
    string           tag     = "";
    ctl_t            m_act;
    exp_t            m_exp;

    // Monitor: one expected entry per cycle, compared away from the clock edge.
    always @(negedge clk) begin
        if (mon_en) begin
            m_act = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel, asel,
                     bff, bsel, alusel, mdrwrite, dmem_wen, trap};
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL no_expected_entry: got ctl=%h instret=%0d, required none", m_act, instret);
            end else begin
                m_exp = q.pop_front();
                if (m_act !== m_exp.ctl || instret !== m_exp.cnt) begin
                    errors++;
                    $display("FAIL %s @%0t: got ctl=%h instret=%0d, required ctl=%h instret=%0d",
                             m_exp.tag, $time, m_act, instret, m_exp.ctl, m_exp.cnt);
                end
            end
        end
    end

    task automatic step(input ctl_t c);
        exp_t e;
        e.ctl = c; e.cnt = exp_cnt; e.tag = tag;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        ctl_t c;
        imem_ready = 1'b0;
        repeat (waits) step('0);
        instr = ins; imem_ready = 1'b1;
        c = '0; c.pcwrite = 1'b1; c.pccen = 1'b1; c.irwrite = 1'b1;
        step(c);
        imem_ready = 1'b0;
    endtask

    task automatic decode(input logic is_jal);
        ctl_t c;
        c = '0; c.asel = ALUA_PCC; c.bsel = 1'b1; c.immsel = is_jal ? IMM_J : IMM_B;
        step(c);
    endtask

    task automatic alu_op(input logic [31:0] ins, input logic is_imm, input logic [3:0] op, input int waits);
        ctl_t c;
        fetch(ins, waits); decode(1'b0);
        c = '0; c.alusel = op; c.bsel = is_imm; c.immsel = IMM_L;
        step(c);
        c = '0; c.regwen = 1'b1; c.wbsel = WB_ALUOUT;
        step(c);
        exp_cnt++;
    endtask

    task automatic memadr(input logic is_store);
        ctl_t c;
        c = '0; c.bsel = 1'b1; c.immsel = is_store ? IMM_S : IMM_L;
        step(c);
    endtask

    task automatic load(input logic [31:0] ins, input int waits);
        ctl_t c;
        fetch(ins, 0); decode(1'b0); memadr(1'b0);
        dmem_ready = 1'b0;
        repeat (waits) step('0);
        dmem_ready = 1'b1;
        c = '0; c.mdrwrite = 1'b1; step(c);
        dmem_ready = 1'b0;
        c = '0; c.regwen = 1'b1; c.wbsel = WB_MDR; step(c);
        exp_cnt++;
    endtask

    task automatic store(input logic [31:0] ins, input int waits);
        ctl_t c;
        fetch(ins, 0); decode(1'b0); memadr(1'b1);
        c = '0; c.dmem_wen = 1'b1;
        dmem_ready = 1'b0;
        repeat (waits) step(c);
        dmem_ready = 1'b1;
        step(c);
        dmem_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic branch(input logic [31:0] ins, input logic z, input logic taken, input logic legal);
        ctl_t c;
        fetch(ins, 0); decode(1'b0);
        zero = z;
        c = '0; c.pcsourse = 1'b1; c.alusel = ALU_SUB; c.pcwrite = taken;
        step(c);
        zero = 1'b0;
        if (legal) exp_cnt++;
    endtask

    task automatic jal_op(input logic [31:0] ins);
        ctl_t c;
        fetch(ins, 0); decode(1'b1);
        c = '0; c.pcwrite = 1'b1; c.pcsourse = 1'b1; c.regwen = 1'b1; c.wbsel = WB_PC;
        step(c);
        exp_cnt++;
    endtask

    // Hold in TRAP with every ready/zero input high; nothing may be enabled.
    task automatic trap_hold(input int n);
        ctl_t c;
        imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
        c = '0; c.trap = 1'b1;
        repeat (n) step(c);
        imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    endtask

    task automatic reset_from(input ctl_t cur);
        rst = 1'b0;
        step(cur);
        exp_cnt = '0;
        step('0);
        rst = 1'b1;
    endtask

    initial begin
        ctl_t c;
        rst = 1'b0; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; instr = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        tag = "reset_gating";
        step('0); step('0);
        rst = 1'b1;

        tag = "addi";        alu_op(32'h00500093, 1'b1, ALU_ADD, 0);
        tag = "addi_istall"; alu_op(32'h00500093, 1'b1, ALU_ADD, 2);
        tag = "add";  alu_op(32'h002081B3, 1'b0, ALU_ADD, 0);
        tag = "sub";  alu_op(32'h40208233, 1'b0, ALU_SUB, 0);
        tag = "sll";  alu_op(32'h002092B3, 1'b0, ALU_SLL, 0);
        tag = "slt";  alu_op(32'h0020A333, 1'b0, ALU_SLT, 0);
        tag = "sltu"; alu_op(32'h0020B3B3, 1'b0, ALU_SLTU, 0);
        tag = "xor";  alu_op(32'h0020C433, 1'b0, ALU_XOR, 0);
        tag = "srl";  alu_op(32'h0020D4B3, 1'b0, ALU_SRL, 0);
        tag = "sra";  alu_op(32'h4020D533, 1'b0, ALU_SRA, 0);
        tag = "or";   alu_op(32'h0020E5B3, 1'b0, ALU_OR, 0);
        tag = "and";  alu_op(32'h0020F633, 1'b0, ALU_AND, 0);
        tag = "addi_bit30"; alu_op(32'h40008093, 1'b1, ALU_ADD, 0);
        tag = "srai"; alu_op(32'h4030D093, 1'b1, ALU_SRA, 0);
        tag = "srli"; alu_op(32'h0030D093, 1'b1, ALU_SRL, 0);
        tag = "xori_bit30"; alu_op(32'h4000C093, 1'b1, ALU_XOR, 0);
        tag = "andi"; alu_op(32'h0FF0F093, 1'b1, ALU_AND, 0);

        tag = "lw_3wait";  load(32'h0040A103, 3);
        tag = "lw_0wait";  load(32'h0040A103, 0);
        tag = "sw_2wait";  store(32'h0020A223, 2);
        tag = "beq_taken";    branch(32'h00108463, 1'b1, 1'b1, 1'b1);
        tag = "beq_nottaken"; branch(32'h00108463, 1'b0, 1'b0, 1'b1);
        tag = "bne_nottaken"; branch(32'h00109463, 1'b1, 1'b0, 1'b1);
        tag = "bne_taken";    branch(32'h00109463, 1'b0, 1'b1, 1'b1);
        tag = "jal";          jal_op(32'h010000EF);

        tag = "illegal_op";
        fetch(32'h0000007F, 0); decode(1'b0);
        trap_hold(4);
        c = '0; c.trap = 1'b1;
        tag = "trap_reset"; reset_from(c);

        tag = "wrap";
        repeat (16) alu_op(32'h00500093, 1'b1, ALU_ADD, 0);
        tag = "post_wrap"; alu_op(32'h00500093, 1'b1, ALU_ADD, 0);

        tag = "sw_abort";
        fetch(32'h0020A223, 0); decode(1'b0); memadr(1'b1);
        dmem_ready = 1'b0;
        c = '0; c.dmem_wen = 1'b1;
        step(c); step(c);
        reset_from('0);

        tag = "blt_trap";
        branch(32'h0010C463, 1'b1, 1'b0, 1'b0);
        trap_hold(2);
        c = '0; c.trap = 1'b1;
        reset_from(c);
        tag = "recover"; alu_op(32'h00500093, 1'b1, ALU_ADD, 0);

        mon_en = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
